// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Owner encoding, default widths and the read-latency bound.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int MEM_LAT_DEF    = 1;
  localparam int MEM_LAT_MAX    = 4;
  localparam int STARVE_LIM_DEF = 4;
  localparam int WAIT_W         = 4;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_ACC  = 1'b1;

  typedef struct packed {
    logic vld;
    logic owner;
  } tag_t;

  function automatic int clamp_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/dmem_arb_tagpipe.sv
// Read-return tag pipeline: DEPTH-stage {valid, owner} shift register.
// Stage 0 loads every cycle; the last stage lines up with returning read data.
module dmem_arb_tagpipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t load_tag,
  output tag_t last_tag
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) stages[k] <= '0;
    end else begin
      stages[0] <= load_tag;
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
    end
  end

  assign last_tag = stages[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Core/accelerator arbiter for the single-port data memory; core priority with a
// starvation limit for the accelerator. DMEM_ARB_STATS_EN adds conflict/forced counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wstrb,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                acc_req,
  input  logic                acc_we,
  input  logic [ADDR_W-1:0]   acc_addr,
  input  logic [DATA_W-1:0]   acc_wdata,
  input  logic [DATA_W/8-1:0] acc_wstrb,
  output logic                acc_gnt,
  output logic                acc_rvalid,
  output logic [DATA_W-1:0]   acc_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]         conflict_cnt,
  output logic [31:0]         forced_cnt
`endif
);

  localparam int                TAG_DEPTH = clamp_lat(MEM_LAT);
  localparam logic [WAIT_W-1:0] LIM       = WAIT_W'(STARVE_LIM);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;
  logic              acc_win;
  logic              core_win;
  logic              accept;
  tag_t              load_tag;
  tag_t              last_tag;

  assign starved  = (wait_cnt == LIM);
  assign acc_win  = acc_req & (~core_req | starved);
  assign core_win = core_req & ~acc_win;
  assign accept   = core_win | acc_win;

  assign core_stall = core_req & ~core_win;
  assign acc_gnt    = acc_win;

  always_comb begin
    mem_en    = accept;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (core_win) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_wstrb = core_wstrb;
    end else if (acc_win) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      mem_wstrb = acc_wstrb;
    end
  end

  // Counts consecutive cycles the accelerator asked and lost, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!acc_req || acc_win) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign load_tag.vld   = accept & ~mem_we;
  assign load_tag.owner = acc_win ? OWN_ACC : OWN_CORE;

  dmem_arb_tagpipe #(
    .DEPTH(TAG_DEPTH)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .load_tag(load_tag),
    .last_tag(last_tag)
  );

  assign core_rvalid = last_tag.vld & (last_tag.owner == OWN_CORE);
  assign acc_rvalid  = last_tag.vld & (last_tag.owner == OWN_ACC);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign acc_rdata   = acc_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
      forced_cnt   <= '0;
    end else begin
      if (core_req && acc_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (acc_win && core_req) forced_cnt <= forced_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus stream.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  typedef struct {
    logic cr;
    logic ar;
    logic stall;
    logic gnt;
    logic en;
  } vec_t;

  typedef struct {
    int          inst;
    int          due;
    logic        own;
    logic [31:0] d;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  logic        core_req, core_we, acc_req, acc_we;
  logic [31:0] core_addr, core_wdata, acc_addr, acc_wdata;
  logic [3:0]  core_wstrb, acc_wstrb;

  logic        core_stall_o [2];
  logic        core_rvalid_o [2];
  logic [31:0] core_rdata_o [2];
  logic        acc_gnt_o [2];
  logic        acc_rvalid_o [2];
  logic [31:0] acc_rdata_o [2];
  logic        mem_en_o [2];
  logic        mem_we_o [2];
  logic [31:0] mem_addr_o [2];
  logic [31:0] mem_wdata_o [2];
  logic [3:0]  mem_wstrb_o [2];
  logic [31:0] mem_rdata_i [2];
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_o [2];
  logic [31:0] forced_o [2];
`endif

  logic [31:0] mem [2][64];
  logic [31:0] rdp [2][4];
  logic [31:0] sh [64];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    tcyc    = 0;
  resp_t exp_q[$];
  vec_t  tv [13];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int a);
    if (a == 4) return 32'hDEADBEEF;
    if (a == 2) return 32'h0;
    return 32'h1357_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT((g == 0) ? 1 : 3), .STARVE_LIM(LIM)
    ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_wstrb(core_wstrb),
      .core_stall(core_stall_o[g]), .core_rvalid(core_rvalid_o[g]),
      .core_rdata(core_rdata_o[g]),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
      .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
      .acc_gnt(acc_gnt_o[g]), .acc_rvalid(acc_rvalid_o[g]), .acc_rdata(acc_rdata_o[g]),
      .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_wstrb(mem_wstrb_o[g]), .mem_rdata(mem_rdata_i[g])
`ifdef DMEM_ARB_STATS_EN
      , .conflict_cnt(conflict_o[g]), .forced_cnt(forced_o[g])
`endif
    );
    assign mem_rdata_i[g] = rdp[g][((g == 0) ? 1 : 3) - 1];
  end

  // Memory model per instance: writes merge by strobe, reads return after the latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int a = 0; a < 64; a++) mem[i][a] <= init_word(a);
      end else if (mem_en_o[i] && mem_we_o[i]) begin
        mem[i][mem_addr_o[i][7:2]] <= merge(mem[i][mem_addr_o[i][7:2]], mem_wdata_o[i],
                                            mem_wstrb_o[i]);
      end
      rdp[i][0] <= (mem_en_o[i] && !mem_we_o[i]) ? mem[i][mem_addr_o[i][7:2]] : 32'($urandom);
      for (int k = 1; k < 4; k++) rdp[i][k] <= rdp[i][k-1];
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b expected %b", nm, tcyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, tcyc, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic [3:0] cs,
                       input logic ar, input logic aw, input logic [31:0] aa,
                       input logic [31:0] ad, input logic [3:0] as);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd; core_wstrb = cs;
    acc_req = ar; acc_we = aw; acc_addr = aa; acc_wdata = ad; acc_wstrb = as;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) sh[a] = init_word(a);
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 3; i < 13; i++) tv[i] = '{1'b1, 1'b1, (i == 7 || i == 12), (i == 7 || i == 12), 1'b1};

    // Reset: arbitration stays live with wait_cnt=0, responses are held off.
    rst = 1'b0;
    mem_init = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("rst_stall[%0d]", i), core_stall_o[i], 1'b0);
      chk1($sformatf("rst_gnt[%0d]", i), acc_gnt_o[i], 1'b0);
      chk1($sformatf("rst_crv[%0d]", i), core_rvalid_o[i], 1'b0);
      chk1($sformatf("rst_arv[%0d]", i), acc_rvalid_o[i], 1'b0);
      chk32($sformatf("rst_crd[%0d]", i), core_rdata_o[i], 32'h0);
    end
    next_cycle();
    next_cycle();
    mem_init = 1'b0;
    idle();
    rst = 1'b1;
    next_cycle();

    // Arbitration table: idle, singles, then ten cycles of contention.
    for (int v = 0; v < 13; v++) begin
      drive(tv[v].cr, 1, 0, 0, 0, tv[v].ar, 1, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("tv%0d_stall[%0d]", v, i), core_stall_o[i], tv[v].stall);
        chk1($sformatf("tv%0d_gnt[%0d]", v, i), acc_gnt_o[i], tv[v].gnt);
        chk1($sformatf("tv%0d_en[%0d]", v, i), mem_en_o[i], tv[v].en);
      end
      next_cycle();
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk32($sformatf("forced_cnt[%0d]", i), forced_o[i], 32'd2);
      chk32($sformatf("conflict_cnt[%0d]", i), conflict_o[i], 32'd10);
    end
`endif
    next_cycle();

    // Core-only read of 0x10.
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("co_stall[%0d]", i), core_stall_o[i], 1'b0);
      chk1($sformatf("co_en[%0d]", i), mem_en_o[i], 1'b1);
    end
    next_cycle();
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("co_crv%0d[%0d]", k, i), core_rvalid_o[i], k == lat_of(i));
        chk32($sformatf("co_crd%0d[%0d]", k, i), core_rdata_o[i],
              (k == lat_of(i)) ? 32'hDEADBEEF : 32'h0);
        chk1($sformatf("co_arv%0d[%0d]", k, i), acc_rvalid_o[i], 1'b0);
      end
      next_cycle();
    end

    // Interleaved owners: core read 0x0 then accelerator read 0x4.
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) drive(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
      else idle();
      @(negedge clk);
      if (k == 1) chk1("il_gnt", acc_gnt_o[1], 1'b1);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("il_crv%0d[%0d]", k, i), core_rvalid_o[i], k == lat_of(i));
        chk32($sformatf("il_crd%0d[%0d]", k, i), core_rdata_o[i],
              (k == lat_of(i)) ? sh[0] : 32'h0);
        chk1($sformatf("il_arv%0d[%0d]", k, i), acc_rvalid_o[i], k == lat_of(i) + 1);
        chk32($sformatf("il_ard%0d[%0d]", k, i), acc_rdata_o[i],
              (k == lat_of(i) + 1) ? sh[1] : 32'h0);
      end
      next_cycle();
    end

    // Partial accelerator write, then core read-back.
    drive(0, 0, 0, 0, 0, 1, 1, 32'h8, 32'hA5A5A5A5, 4'h3);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("wr_gnt[%0d]", i), acc_gnt_o[i], 1'b1);
      chk1($sformatf("wr_we[%0d]", i), mem_we_o[i], 1'b1);
      chk32($sformatf("wr_strb[%0d]", i), 32'(mem_wstrb_o[i]), 32'h3);
    end
    next_cycle();
    idle();
    sh[2] = merge(sh[2], 32'hA5A5A5A5, 4'h3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("wr_crv%0d[%0d]", k, i), core_rvalid_o[i], 1'b0);
        chk1($sformatf("wr_arv%0d[%0d]", k, i), acc_rvalid_o[i], 1'b0);
      end
      next_cycle();
    end
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("rb_crv%0d[%0d]", k, i), core_rvalid_o[i], k == lat_of(i));
        chk32($sformatf("rb_crd%0d[%0d]", k, i), core_rdata_o[i],
              (k == lat_of(i)) ? 32'h0000A5A5 : 32'h0);
      end
      next_cycle();
    end

    // Reset while a core read is in flight and wait_cnt is nonzero.
    drive(1, 0, 32'h0, 0, 0, 1, 0, 32'h4, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk1($sformatf("mr_stall[%0d]", i), core_stall_o[i], 1'b0);
    next_cycle();
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk32("mr_wait[0]", 32'(g_dut[0].u_dut.wait_cnt), 32'h0);
    chk32("mr_wait[1]", 32'(g_dut[1].u_dut.wait_cnt), 32'h0);
    for (int i = 0; i < 2; i++) chk1($sformatf("mr_crv0[%0d]", i), core_rvalid_o[i], 1'b0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 0, 1, 0, 32'h4, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("mr_rstall[%0d]", i), core_stall_o[i], 1'b0);
      chk1($sformatf("mr_rgnt[%0d]", i), acc_gnt_o[i], 1'b0);
    end
    next_cycle();
    idle();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("mr_crv%0d[%0d]", k, i), core_rvalid_o[i], 1'b0);
        chk1($sformatf("mr_arv%0d[%0d]", k, i), acc_rvalid_o[i], 1'b0);
      end
      next_cycle();
    end

    // Accelerator alone: granted immediately, never accumulates wait.
    drive(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk1($sformatf("aa_gnt%0d[%0d]", k, i), acc_gnt_o[i], 1'b1);
      chk32($sformatf("aa_wait%0d[0]", k), 32'(g_dut[0].u_dut.wait_cnt), 32'h0);
      chk32($sformatf("aa_wait%0d[1]", k), 32'(g_dut[1].u_dut.wait_cnt), 32'h0);
      next_cycle();
    end
    idle();
    for (int k = 0; k < 5; k++) next_cycle();

    // Randomized traffic against a rule-level model.
    begin
      int lost;
      lost = 0;
      for (int c = 0; c < 650; c++) begin
        logic cr, cw, ar, aw, a_win, c_win, acc_ok, ecv, eav;
        logic [31:0] ca, cd, aa, ad, ecd, ead, w_addr, w_data;
        logic [3:0] cs, as, w_strb;
        logic w_we;
        cr = (c < 600) && ($urandom_range(0, 99) < 60);
        ar = (c < 600) && ($urandom_range(0, 99) < 55);
        cw = 1'($urandom); aw = 1'($urandom);
        ca = {24'h0, 6'($urandom), 2'b00}; aa = {24'h0, 6'($urandom), 2'b00};
        cd = $urandom; ad = $urandom;
        cs = 4'($urandom); as = 4'($urandom);
        drive(cr, cw, ca, cd, cs, ar, aw, aa, ad, as);

        a_win  = ar && (!cr || lost >= LIM);
        c_win  = cr && !a_win;
        acc_ok = a_win || c_win;
        w_we   = c_win ? cw : (a_win ? aw : 1'b0);
        w_addr = c_win ? ca : (a_win ? aa : 32'h0);
        w_data = c_win ? cd : (a_win ? ad : 32'h0);
        w_strb = c_win ? cs : (a_win ? as : 4'h0);

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          ecv = 1'b0; eav = 1'b0; ecd = 32'h0; ead = 32'h0;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].inst == i && exp_q[j].due == tcyc) begin
              if (exp_q[j].own) begin eav = 1'b1; ead = exp_q[j].d; end
              else begin ecv = 1'b1; ecd = exp_q[j].d; end
              exp_q.delete(j);
              break;
            end
          end
          chk1($sformatf("rnd_stall[%0d]", i), core_stall_o[i], cr && !c_win);
          chk1($sformatf("rnd_gnt[%0d]", i), acc_gnt_o[i], a_win);
          chk1($sformatf("rnd_en[%0d]", i), mem_en_o[i], acc_ok);
          chk1($sformatf("rnd_we[%0d]", i), mem_we_o[i], w_we);
          chk32($sformatf("rnd_addr[%0d]", i), mem_addr_o[i], w_addr);
          chk32($sformatf("rnd_wdata[%0d]", i), mem_wdata_o[i], w_data);
          chk32($sformatf("rnd_wstrb[%0d]", i), 32'(mem_wstrb_o[i]), 32'(w_strb));
          chk1($sformatf("rnd_crv[%0d]", i), core_rvalid_o[i], ecv);
          chk32($sformatf("rnd_crd[%0d]", i), core_rdata_o[i], ecd);
          chk1($sformatf("rnd_arv[%0d]", i), acc_rvalid_o[i], eav);
          chk32($sformatf("rnd_ard[%0d]", i), acc_rdata_o[i], ead);
        end

        if (acc_ok && !w_we) begin
          for (int i = 0; i < 2; i++)
            exp_q.push_back('{i, tcyc + lat_of(i), a_win, sh[w_addr[7:2]]});
        end else if (acc_ok) begin
          sh[w_addr[7:2]] = merge(sh[w_addr[7:2]], w_data, w_strb);
        end
        if (!ar || a_win) lost = 0;
        else if (lost < LIM) lost++;
        next_cycle();
      end
    end
    chk32("rnd_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the pipelined RISC-V core's single-port data memory between the core's MEM stage and the CNN accelerator's load/store port. One access is issued per cycle. The core has priority, but a starvation limit guarantees the accelerator forward progress. A tag pipeline routes each read's data back to its issuer. The block sits between the core, the accelerator and the data memory, inside the `riscv` top.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- MEM_LAT, 1, memory read latency in cycles (1..4)
- STARVE_LIM, 4, consecutive lost cycles before the accelerator is forced a grant (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- core_req  in  1  core access request; held until accepted
- core_we  in  1  core write enable
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_wstrb  in  DATA_W/8  core byte strobes
- core_stall  out  1  core request not accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- acc_req, acc_we, acc_addr, acc_wdata, acc_wstrb  in  as core  accelerator request bundle
- acc_gnt  out  1  accelerator request accepted this cycle
- acc_rvalid  out  1  accelerator read data valid
- acc_rdata  out  DATA_W  accelerator read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr, mem_wdata, mem_wstrb  out  as above  memory command
- mem_rdata  in  DATA_W  read data, MEM_LAT cycles after mem_en & ~mem_we

## Operation
- Accept rules:
  - Core: core_req & ~core_stall in a cycle.
  - Accelerator: acc_req & acc_gnt in a cycle.
  - At most one accept per cycle.
- Winner selection, combinational from requests and wait_cnt:
  - Only one requester active: it wins.
  - Both active and wait_cnt < STARVE_LIM: core wins.
  - Both active and wait_cnt == STARVE_LIM: accelerator wins; core_stall=1.
- wait_cnt is a 4-bit counter:
  - Increments each cycle acc_req & ~acc_gnt.
  - Clears on an accelerator accept or when acc_req=0.
  - Saturates at STARVE_LIM.
- Memory command: mem_en=1 iff an accept occurs. mem_we, mem_addr, mem_wdata and mem_wstrb are muxed from the winner. When idle they are driven 0.
- core_stall = core_req & ~core_win.
- Read-return tag pipeline:
  - MEM_LAT stages, each holding {valid, owner}.
  - Stage 0 loads {accepted read, winner}. A write loads valid=0.
  - Last stage valid & owner=CORE: core_rvalid=1, core_rdata=mem_rdata.
  - Last stage valid & owner=ACC: acc_rvalid=1, acc_rdata=mem_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
- Writes produce no response. Accept is completion.

## Timing
- Reset (rst=0): tag pipeline, wait_cnt and any stats counters are zeroed asynchronously.
- Output values during reset:
  - core_rvalid=0, acc_rvalid=0, rdata=0.
  - core_stall and acc_gnt follow the combinational rules with wait_cnt=0.
- Reset mid-operation discards in-flight reads. No rvalid is produced for them after rst deasserts.
- Read latency is exactly MEM_LAT cycles from the accept edge to rvalid. Back-to-back reads return in order, one per cycle.
- Mixed owners are interleaved correctly. A core read followed by an accelerator read returns core_rvalid on cycle N and acc_rvalid on cycle N+1.
- A requester changing address/data without an accept is legal; the arbiter holds no request state.

## Configuration
- DMEM_ARB_STATS_EN defined adds two outputs:
  - conflict_cnt (32-bit): cycles with core_req & acc_req.
  - forced_cnt (32-bit): starvation-forced accelerator grants.
  - Both wrap at 2^32 and are cleared by reset.
- DMEM_ARB_STATS_EN undefined: the ports and counters do not exist. Arbitration behaviour is identical.

## Structure
- Package dmem_arb_pkg holds:
  - owner encoding constants OWN_CORE=0, OWN_ACC=1.
  - default widths and the MEM_LAT maximum (4).
- Sub-module dmem_arb_tagpipe implements the MEM_LAT-deep {valid, owner} shift register with asynchronous active-low clear.
- Arbitration logic and wait_cnt live in the top.

## Test plan
- Core only: read addr 0x10 (mem holds 0xDEADBEEF), MEM_LAT=1.
  - Same cycle: core_stall=0, mem_en=1.
  - Next cycle: core_rvalid=1, core_rdata=0xDEADBEEF; acc_rvalid stays 0.
- Continuous contention, both requesting every cycle, STARVE_LIM=4.
  - Core wins 4 cycles, accelerator wins the 5th (core_stall=1), pattern repeats.
  - With DMEM_ARB_STATS_EN: forced_cnt=2 after 10 cycles.
- Interleaved reads, MEM_LAT=3: core read 0x0, then accelerator read 0x4 next cycle.
  - core_rvalid 3 cycles after the first accept.
  - acc_rvalid one cycle later, each with its own word.
- Write then read: accelerator writes 0xA5A5A5A5 with wstrb=0x3 to a location holding 0.
  - No rvalid for the write.
  - Core read of the same address returns 0x0000A5A5.
- Reset mid-flight: core read accepted, rst=0 on the next cycle, released 2 cycles later.
  - core_rvalid never asserts; wait_cnt=0.
- Accelerator alone: acc_gnt=1 on the request cycle, wait_cnt stays 0.
